// File: rtl/ofifo_pkg.sv
// =============================================================================
// Module      : ofifo_pkg
// Description : Shared defaults and pointer-width helper for the output FIFO.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package ofifo_pkg;

    localparam int COL         = 8;
    localparam int PSUM_BW     = 16;
    localparam int OFIFO_DEPTH = 16;

    // Extra MSB beyond the address bits distinguishes full from empty.
    function automatic int ptr_w(input int d);
        return $clog2(d) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ofifo_col.sv
// =============================================================================
// Module      : ofifo_col
// Description : One column queue of the output FIFO; circular buffer with a
//               registered read port.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module ofifo_col
    import ofifo_pkg::*;
#(
    parameter int psum_bw = PSUM_BW,
    parameter int depth   = OFIFO_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr,
    input  logic               rd,
    input  logic [psum_bw-1:0] in,
    output logic [psum_bw-1:0] out,
    output logic               empty,
    output logic               full
);

    localparam int c_pw = ptr_w(depth);
    localparam int c_aw = c_pw - 1;

    logic [c_pw-1:0]    r_wr_ptr;
    logic [c_pw-1:0]    r_rd_ptr;
    logic [psum_bw-1:0] r_out;
    logic [psum_bw-1:0] r_mem [depth];

    logic w_pop;
    logic w_push;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                   (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);

    // A pop in the same cycle frees the slot a write to a full queue needs.
    assign w_pop  = rd && !empty;
    assign w_push = wr && (!full || w_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_out    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_out    <= r_mem[r_rd_ptr[c_aw-1:0]];
            end
        end
    end

    // Storage is deliberately left unreset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= in;
        end
    end

    assign out = r_out;

endmodule

`default_nettype wire

// File: rtl/ofifo.sv
// =============================================================================
// Module      : ofifo
// Description : Output FIFO absorbing the skewed per-column psum stream of the
//               MAC array; pops a whole row at once.
//               Optional feature macro: OFIFO_DROP_CNT_EN (adds drop_cnt).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module ofifo
    import ofifo_pkg::*;
#(
    parameter int col     = COL,
    parameter int psum_bw = PSUM_BW,
    parameter int depth   = OFIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready
`ifdef OFIFO_DROP_CNT_EN
    ,
    output logic [15:0]            drop_cnt
`endif
);

    logic [col-1:0] w_empty;
    logic [col-1:0] w_full;
    logic           w_rd;

    assign o_valid = ~|w_empty;
    assign o_full  = |w_full;
    assign o_ready = ~o_full;

    // Rows pop only once every column has an entry.
    assign w_rd = rd & o_valid;

    for (genvar c = 0; c < col; c++) begin : g_col
        ofifo_col #(
            .psum_bw (psum_bw),
            .depth   (depth)
        ) u_col (
            .clk   (clk),
            .reset (reset),
            .wr    (wr[c]),
            .rd    (w_rd),
            .in    (in[psum_bw*c +: psum_bw]),
            .out   (out[psum_bw*c +: psum_bw]),
            .empty (w_empty[c]),
            .full  (w_full[c])
        );
    end

`ifdef OFIFO_DROP_CNT_EN
    logic [col-1:0] w_drop;
    logic [16:0]    w_drop_num;
    logic [16:0]    w_drop_sum;
    logic [15:0]    r_drop_cnt;

    assign w_drop = wr & w_full & ~{col{w_rd}};

    always_comb begin
        w_drop_num = '0;
        for (int c = 0; c < col; c++) begin
            w_drop_num = w_drop_num + 17'(w_drop[c]);
        end
    end

    assign w_drop_sum = {1'b0, r_drop_cnt} + w_drop_num;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_drop_cnt <= '0;
        end else begin
            r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ofifo.sv
// =============================================================================
// Module      : tb_ofifo
// Description : Directed self-checking bench for ofifo (default 8 x 16b x 16).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_ofifo;

    logic         clk;
    logic         reset;
    logic [127:0] din;
    logic [7:0]   wr;
    logic         rd;
    logic [127:0] dout;
    logic         o_valid;
    logic         o_full;
    logic         o_ready;
`ifdef OFIFO_DROP_CNT_EN
    logic [15:0]  drop_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    ofifo dut (
        .clk     (clk),
        .reset   (reset),
        .in      (din),
        .wr      (wr),
        .rd      (rd),
        .out     (dout),
        .o_valid (o_valid),
        .o_full  (o_full),
        .o_ready (o_ready)
`ifdef OFIFO_DROP_CNT_EN
        ,
        .drop_cnt(drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] make_bus(input int base, input int stride);
        logic [127:0] b;
        for (int c = 0; c < 8; c++) begin
            b[c*16 +: 16] = 16'(base + stride * c);
        end
        return b;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        wr    = '0;
        rd    = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] exp;

        reset = 1'b0;
        wr    = '0;
        rd    = 1'b0;
        din   = '0;

        // Reset state
        step();
        check("rst_valid", 128'(o_valid), 128'(1'b0));
        check("rst_full",  128'(o_full),  128'(1'b0));
        check("rst_ready", 128'(o_ready), 128'(1'b1));
        check("rst_out",   dout, '0);
        @(negedge clk);
        reset = 1'b1;

        // Single row write then pop
        wr  = 8'hFF;
        din = make_bus(0, 1);
        step();
        wr = '0;
        check("row_valid", 128'(o_valid), 128'(1'b1));
        rd = 1'b1;
        step();
        rd = 1'b0;
        check("row_out",    dout, make_bus(0, 1));
        check("row_valid0", 128'(o_valid), 128'(1'b0));

        // rd on empty queue leaves out untouched
        rd = 1'b1;
        step();
        rd = 1'b0;
        check("empty_rd_out", dout, make_bus(0, 1));

        // Skewed column writes
        do_reset();
        for (int k = 0; k < 8; k++) begin
            wr  = 8'((1 << (k + 1)) - 1);
            din = make_bus(k * 16, 1);
            step();
            check($sformatf("skew_valid_%0d", k), 128'(o_valid), 128'(k == 7));
        end
        wr = '0;
        rd = 1'b1;
        step();
        rd = 1'b0;
        check("skew_out", dout, make_bus(0, 17));

        // Fill, drop on full, drain in order
        do_reset();
        wr = 8'hFF;
        for (int k = 0; k < 16; k++) begin
            din = make_bus(k * 256, 1);
            step();
        end
        check("fill_full",  128'(o_full),  128'(1'b1));
        check("fill_ready", 128'(o_ready), 128'(1'b0));
        din = make_bus(16'hBEEF, 0);
        step();
        wr = '0;
        check("drop_full", 128'(o_full), 128'(1'b1));
`ifdef OFIFO_DROP_CNT_EN
        check("drop_cnt", 128'(drop_cnt), 128'(16'd8));
`endif
        rd = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step();
            check($sformatf("drain_%0d", k), dout, make_bus(k * 256, 1));
        end
        rd = 1'b0;
        check("drain_valid", 128'(o_valid), 128'(1'b0));
        check("drain_full",  128'(o_full),  128'(1'b0));

        // Simultaneous pop and write on a full queue
        do_reset();
        wr = 8'hFF;
        for (int k = 0; k < 16; k++) begin
            din = make_bus(k * 256, 1);
            step();
        end
        rd  = 1'b1;
        din = make_bus(16'hAAAA, 0);
        step();
        wr = '0;
        check("rw_out0", dout, make_bus(0, 1));
        check("rw_full", 128'(o_full), 128'(1'b1));
        for (int k = 1; k < 16; k++) begin
            step();
            check($sformatf("rw_pop_%0d", k), dout, make_bus(k * 256, 1));
        end
        step();
        rd = 1'b0;
        check("rw_last", dout, make_bus(16'hAAAA, 0));
        check("rw_valid", 128'(o_valid), 128'(1'b0));

        // rd ignored while column 3 is empty
        do_reset();
        wr  = 8'hF7;
        din = make_bus(16'h100, 1);
        step();
        wr = '0;
        check("c3_valid", 128'(o_valid), 128'(1'b0));
        rd = 1'b1;
        step();
        rd = 1'b0;
        check("c3_out_held", dout, '0);
        wr  = 8'h08;
        din = make_bus(16'h300, 0);
        step();
        wr = '0;
        check("c3_valid1", 128'(o_valid), 128'(1'b1));
        rd = 1'b1;
        step();
        rd = 1'b0;
        exp = make_bus(16'h100, 1);
        exp[63:48] = 16'h0300;
        check("c3_out", dout, exp);

        // Asynchronous reset mid-operation; first edge after release writes
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        wr    = 8'hFF;
        for (int k = 0; k < 5; k++) begin
            din = make_bus(16'h500 + k * 16, 1);
            step();
        end
        wr = '0;
        check("ar_valid", 128'(o_valid), 128'(1'b1));
        rd = 1'b1;
        step();
        rd = 1'b0;
        check("ar_out", dout, make_bus(16'h500, 1));
        #3;
        reset = 1'b0;
        #2;
        check("ar_valid_async", 128'(o_valid), 128'(1'b0));
        check("ar_out_async",   dout, '0);
        check("ar_ready_async", 128'(o_ready), 128'(1'b1));
        @(negedge clk);
        reset = 1'b1;
        step();
        check("ar_post_valid", 128'(o_valid), 128'(1'b0));
        check("ar_post_out",   dout, '0);
        wr  = 8'hFF;
        din = make_bus(16'h600, 1);
        step();
        wr = '0;
        rd = 1'b1;
        step();
        rd = 1'b0;
        check("ar_fresh_out", dout, make_bus(16'h600, 1));
        check("ar_fresh_valid", 128'(o_valid), 128'(1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ofifo.md
OFIFO -- requirements
Module: ofifo

Interface
REQ-001 Parameter col, default 8: number of columns; matches the MAC array column count.
REQ-002 Parameter psum_bw, default 16: partial-sum width per column.
REQ-003 Parameter depth, default 16: entries per column queue; power of 2 and at least 2.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 in  input  psum_bw*col  psum bus from the MAC array south outputs; column c occupies bits [psum_bw*(c+1)-1 : psum_bw*c].
REQ-007 wr  input  col  per-column write strobe, driven by the MAC array valid vector.
REQ-008 rd  input  1  pop request; pops one entry from every column.
REQ-009 out  output  psum_bw*col  registered read data, same column packing as in.
REQ-010 o_valid  output  1  every column queue holds at least one entry.
REQ-011 o_full  output  1  at least one column queue is full.
REQ-012 o_ready  output  1  equals the inverse of o_full.

Function
REQ-013 Each column c shall be an independent circular queue of depth entries, written when wr[c]=1.
REQ-014 Columns shall accept writes in different cycles; the array's skewed valid pattern is absorbed, so a row completes when the last column writes.
REQ-015 A write to a column that is not full shall store in[c] at the write pointer and advance that pointer on the same edge.
REQ-016 A write to a full column with no pop in the same cycle shall be dropped; stored data and pointers stay unchanged.
REQ-017 A pop shall occur only when rd=1 and o_valid=1; rd=1 with o_valid=0 shall be ignored, with no state change and out held.
REQ-018 On a pop, every column's head entry shall be loaded into out on that edge, so out is visible the cycle after rd (latency 1).
REQ-019 On a pop, every read pointer shall advance by one.
REQ-020 out shall hold its value until the next pop.
REQ-021 Write and pop in the same cycle on a full column: the pop frees a slot and the write is accepted.
REQ-022 Write and rd in the same cycle on an empty column: the write is accepted, the rd is ignored, and there is no bypass path.
REQ-023 Pointers shall be log2(depth)+1 bits and wrap modulo 2*depth.
REQ-024 Full: pointer MSBs differ and the low bits are equal. Empty: the pointers are equal.
REQ-025 o_valid, o_full and o_ready shall be combinational decodes of the current pointers only, with no path from in, wr or rd.

Reset
REQ-026 While reset=0, all pointers shall be 0, out shall be 0, o_valid=0, o_full=0 and o_ready=1.
REQ-027 Reset asserted mid-operation shall discard all stored entries immediately, without waiting for a clock edge.
REQ-028 Entry storage need not be cleared by reset.
REQ-029 The first write is accepted on the first rising edge after reset returns to 1.

Configuration
REQ-030 When OFIFO_DROP_CNT_EN is defined, the block shall add output drop_cnt (16 bits).
REQ-031 drop_cnt shall increment by the number of columns whose write was dropped in that cycle (REQ-016), saturate at 16'hFFFF, and reset to 0.
REQ-032 When OFIFO_DROP_CNT_EN is undefined, the drop_cnt port and its logic shall be absent, and all other behaviour shall be identical.

Structure
REQ-033 A shared package shall hold the default constants (COL=8, PSUM_BW=16, OFIFO_DEPTH=16) and a pointer-width function based on clog2.
REQ-034 One sub-module, ofifo_col, shall implement a single column queue: ports clk, reset, wr, rd, in, out, empty, full.
REQ-035 ofifo shall instantiate col copies of ofifo_col via generate and gate each column's rd with the global o_valid.

Verification
REQ-036 Reset release, then wr=8'hFF with in = column index (0..7) for 1 cycle -> o_valid=1; rd pulse -> out = {7,6,...,0} one cycle later and o_valid=0.
REQ-037 Skewed writes: wr=8'h01, 8'h03 ... 8'hFF on consecutive cycles -> o_valid rises only on the cycle after the wr=8'hFF edge.
REQ-038 Fill: 16 writes of wr=8'hFF -> o_full=1 and o_ready=0; a 17th write with a new value is dropped; 16 pops return the first 16 values in order.
REQ-039 Full queue, rd=1 together with wr=8'hFF and value 0xAAAA -> the write is accepted, o_full stays 1, and 0xAAAA is the last value popped.
REQ-040 rd=1 with column 3 empty and all other columns non-empty -> out unchanged and no pointer moves.
REQ-041 Reset=0 asynchronously between clock edges after 5 writes -> o_valid=0 immediately, and after release out=0 and the queue is empty.
